// File: rtl/fram_buf_pkg.sv
// Constants shared by the frame write buffer packer and the DDR write engine.
// The write side stores 32-bit pixel pairs; the read side drains 128-bit words.
package fram_buf_pkg;
  localparam int PIX_WIDTH     = 16;
  localparam int WR_DATA_WIDTH = 32;
  localparam int WR_ADDR_WIDTH = 10;
  localparam int RD_DATA_WIDTH = 128;
  localparam int RD_ADDR_WIDTH = 8;
  localparam int HALF_WORDS    = 2 ** (WR_ADDR_WIDTH - 1);
endpackage

// File: rtl/fram_pix_pair.sv
// Pairs consecutive valid pixels into one word (first pixel in the low half)
// and pads a lone pixel left over when data enable drops.
module fram_pix_pair #(
  parameter int PIX_WIDTH = fram_buf_pkg::PIX_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_restart,
  input  logic                   i_de,
  input  logic [PIX_WIDTH-1:0]   i_pix,
  output logic                   o_word_valid,
  output logic [2*PIX_WIDTH-1:0] o_word
);
  logic                 r_held_valid;
  logic [PIX_WIDTH-1:0] r_held_pix;
  logic                 w_hold;

  // A restart discards any held pixel, so the pixel on that edge starts a pair.
  assign w_hold = i_de & (i_restart | ~r_held_valid);

  always_comb begin
    o_word_valid = 1'b0;
    o_word       = '0;
    if (!i_restart && r_held_valid) begin
      o_word_valid = 1'b1;
      o_word       = i_de ? {i_pix, r_held_pix} : {{PIX_WIDTH{1'b0}}, r_held_pix};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_held_valid <= 1'b0;
      r_held_pix   <= '0;
    end else begin
      r_held_valid <= w_hold;
      if (w_hold) r_held_pix <= i_pix;
    end
  end
endmodule

// File: rtl/wr_fram_pack.sv
// Packs the capture stream into the frame buffer write port as two ping-pong
// halves and raises a level request to the DDR writer for each full half.
module wr_fram_pack #(
  parameter int PIX_WIDTH     = fram_buf_pkg::PIX_WIDTH,
  parameter int WR_DATA_WIDTH = fram_buf_pkg::WR_DATA_WIDTH,
  parameter int WR_ADDR_WIDTH = fram_buf_pkg::WR_ADDR_WIDTH
) (
  input  logic                     wr_clk,
  input  logic                     wr_rst,
  input  logic                     vs_in,
  input  logic                     de_in,
  input  logic [PIX_WIDTH-1:0]     pix_in,
  output logic                     wr_en,
  output logic [WR_ADDR_WIDTH-1:0] wr_addr,
  output logic [WR_DATA_WIDTH-1:0] wr_data,
  output logic                     burst_req,
  output logic                     burst_half,
  input  logic                     burst_done,
  output logic                     frame_start,
  output logic                     overflow
);
  localparam logic [WR_ADDR_WIDTH-1:0] ADDR_ONE = 1;

  logic                     r_vs_d;
  logic [1:0]               r_pend;
  logic                     r_rd_half;
  logic                     r_wr_en;
  logic [WR_ADDR_WIDTH-1:0] r_wr_addr;
  logic [WR_DATA_WIDTH-1:0] r_wr_data;
  logic                     r_burst_req;
  logic                     r_frame_start;
  logic                     r_overflow;

  logic                     w_vs_rise;
  logic                     w_done;
  logic                     w_half_full;
  logic                     w_word_valid;
  logic [WR_DATA_WIDTH-1:0] w_word;
  logic [1:0]               w_pend_nxt;
  logic                     w_rd_half_nxt;

  assign w_vs_rise   = vs_in & ~r_vs_d;
  assign w_done      = burst_done & r_burst_req;
  // The write now on the port is the last word of its half.
  assign w_half_full = r_wr_en & (&r_wr_addr[WR_ADDR_WIDTH-2:0]);

  fram_pix_pair #(.PIX_WIDTH(PIX_WIDTH)) u_pair (
    .i_clk        (wr_clk),
    .i_rst        (wr_rst),
    .i_restart    (w_vs_rise),
    .i_de         (de_in),
    .i_pix        (pix_in),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // Fill and drain always concern different halves, so both may apply at once.
  always_comb begin
    w_pend_nxt    = r_pend;
    w_rd_half_nxt = r_rd_half;
    if (w_half_full) w_pend_nxt[r_wr_addr[WR_ADDR_WIDTH-1]] = 1'b1;
    if (w_done) begin
      w_pend_nxt[r_rd_half] = 1'b0;
      w_rd_half_nxt         = ~r_rd_half;
    end
    if (w_vs_rise) begin
      w_pend_nxt    = 2'b00;
      w_rd_half_nxt = 1'b0;
    end
  end

  // wr_addr holds the address of the write on the port; it steps after that write.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      r_vs_d        <= 1'b0;
      r_pend        <= 2'b00;
      r_rd_half     <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_burst_req   <= 1'b0;
      r_frame_start <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_vs_d        <= vs_in;
      r_frame_start <= w_vs_rise;
      r_pend        <= w_pend_nxt;
      r_rd_half     <= w_rd_half_nxt;
      r_burst_req   <= w_pend_nxt[w_rd_half_nxt];
      r_wr_en       <= 1'b0;
      if (w_vs_rise) begin
        r_wr_addr <= '0;
      end else begin
        if (r_wr_en) r_wr_addr <= r_wr_addr + ADDR_ONE;
        if (w_word_valid) begin
          if (r_pend[r_wr_addr[WR_ADDR_WIDTH-1]]) begin
            r_overflow <= 1'b1;
          end else begin
            r_wr_en   <= 1'b1;
            r_wr_data <= w_word;
          end
        end
      end
    end
  end

  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign burst_req   = r_burst_req;
  assign burst_half  = r_rd_half;
  assign frame_start = r_frame_start;
  assign overflow    = r_overflow;
endmodule

// File: doc/wr_fram_pack.md
# wr_fram_pack

Upstream feeder for the frame write buffer. Takes the video capture stream (vsync, data enable, 16-bit RGB565 pixels) on the write clock and packs pixel pairs into 32-bit words. It writes those words into the 1024 x 32 write port of the frame buffer RAM as two 512-word ping-pong halves. When a half is full it raises a level request to the DDR write engine, which drains that half through the 128-bit read port and returns `burst_done`.

## Interface
- `PIX_WIDTH`, 16, input pixel width.
- `WR_DATA_WIDTH`, 32, RAM write word; must equal 2*`PIX_WIDTH`.
- `WR_ADDR_WIDTH`, 10, RAM write address width; half size `HALF_WORDS` = 2**(`WR_ADDR_WIDTH`-1) = 512.
- `wr_clk` in 1: the single clock.
- `wr_rst` in 1: reset. Synchronous, active-high.
- `vs_in` in 1: vertical sync, active-high; its rising edge starts a frame.
- `de_in` in 1: pixel valid.
- `pix_in` in `PIX_WIDTH`: pixel, valid when `de_in`=1.
- `wr_en` out 1: RAM write strobe.
- `wr_addr` out `WR_ADDR_WIDTH`: RAM write address.
- `wr_data` out `WR_DATA_WIDTH`: RAM write data.
- `burst_req` out 1: level; the half `burst_half` is full and unread.
- `burst_half` out 1: index of the oldest full half (0 = addr 0..511, 1 = 512..1023).
- `burst_done` in 1: one-cycle pulse from the DDR writer; the requested half is consumed.
- `frame_start` out 1: one-cycle pulse on each frame restart.
- `overflow` out 1: sticky; a word was dropped because its half was still pending.

## Operation
- Pairing: first pixel of a pair goes to `wr_data[15:0]`, second to `[31:16]`. A pair completes on the second `de_in`=1 cycle.
- Odd line end: `de_in` falls with one pixel held. The block writes that pixel as a word with upper half 0.
- Write address: `wr_addr` advances by 1 after each performed write and wraps 1023 -> 0.
- Half fill flags: writing a word whose address low 9 bits are 511 sets `pend[wr_addr[9]]`.
- Request: `rd_half` starts at 0. `burst_half` = `rd_half`; `burst_req` = `pend[rd_half]`.
- Completion: `burst_done` while `burst_req`=1 clears `pend[rd_half]` and toggles `rd_half`. `burst_done` while `burst_req`=0 is ignored.
- Overflow: a completed word targets a half whose `pend` bit is set. The word is dropped, no `wr_en`, address not advanced, `overflow` set. `overflow` clears only on `wr_rst`.
- Frame restart on `vs_in` rising edge (registered edge detect):
  - Held pixel and partial half are discarded.
  - `wr_addr` -> 0, `rd_half` -> 0, `pend` -> 00.
  - A pending burst is aborted; the DDR writer restarts on `frame_start`.
  - If the restart and `de_in` fall in the same cycle, the restart wins and `de_in` is processed as the first pixel of the new frame.
- Simultaneous `pend` set and `burst_done`: both apply. They always concern different halves.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `burst_req`=0, `burst_half`=0, `frame_start`=0, `overflow`=0. Internal `pend`=00, `rd_half`=0, held pixel empty, vs delay register=0.
- All outputs are registered.
- Second pixel of a pair sampled at edge N -> `wr_en`/`wr_addr`/`wr_data` valid in cycle N+1.
- Word with address low bits 511 written in cycle N+1 -> `burst_req`=1 from cycle N+2.
- `burst_done` sampled at edge M -> `burst_req` and `burst_half` update in cycle M+1.
- `vs_in` first sampled 1 at edge N -> `frame_start`=1 in cycle N+1 only. The state reset takes effect at edge N, so a pixel at edge N already belongs to the new frame.
- Throughput: one word every second pixel cycle; no back-pressure to the video source.

## Structure
- Shared package `fram_buf_pkg`: `PIX_WIDTH`, `WR_DATA_WIDTH`, `WR_ADDR_WIDTH`, `RD_DATA_WIDTH`=128, `RD_ADDR_WIDTH`=8, `HALF_WORDS`. The DDR write engine uses the same constants.
- Optional sub-module `fram_pix_pair`: pixel pairing and odd-pixel padding, producing word valid plus word. `wr_fram_pack` owns addressing, the ping-pong flags and the handshake.

## Test plan
- Reset, then 1024 pixels `pix_in`=k with `de_in` continuous:
  - Required: 512 writes, word j = {2j+1, 2j}, addresses 0..511.
  - Required: `burst_req`=1 with `burst_half`=0 two cycles after the 1024th pixel.
- Odd line of 3 pixels A, B, C then `de_in`=0:
  - Required: writes {B,A} at addr 0 and {0,C} at addr 1.
- Fill both halves (2048 pixels) with no `burst_done`, then send 2 more pixels:
  - Required: no `wr_en`, `overflow`=1, `wr_addr` stays 0.
  - Then pulse `burst_done`: required `burst_half`=1 next cycle, `burst_req` still 1.
- `burst_done` while `burst_req`=0 -> no state change.
- Pulse `vs_in` after 300 words:
  - Required: `frame_start` one cycle.
  - Required: next pair written at addr 0, no `burst_req` for the discarded partial half.
- Assert `wr_rst` mid-line with `overflow`=1 -> all outputs at reset values on the next cycle; `overflow`=0.
